// File: rtl/dual_bus_responder.sv
// Two-port (instruction read / data read-write) single-ported memory responder with wait states.
// Optional macro DUAL_BUS_RESPONDER_RR_EN: round-robin tie break instead of fixed data priority.
module dual_bus_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:1] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_out,
    input  logic [19:1] data_m_addr,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    output logic        data_m_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            wait_cnt;
    logic                  gnt_data;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_wr;
    logic [1:0]            lat_bsel;
    logic [15:0]           lat_wdata;
    logic [15:0]           instr_rd;
    logic [15:0]           data_rd;
    logic [15:0]           mem [2**ADDR_WIDTH];

    logic                  any_req;
    logic                  pick_data;
    logic                  enter_ack;
    logic                  acc_data;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_wr;
    logic [1:0]            acc_bsel;
    logic [15:0]           acc_wdata;
    logic                  unused_addr_bits;

    // Upper address bits are intentionally ignored so addresses alias.
    assign unused_addr_bits = ^{instr_m_addr[19:ADDR_WIDTH+1], data_m_addr[19:ADDR_WIDTH+1]};
    assign any_req = instr_m_access | data_m_access;

`ifdef DUAL_BUS_RESPONDER_RR_EN
    logic last_data;

    assign pick_data = data_m_access & (~instr_m_access | ~last_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_data <= pick_data;
        end
    end
`else
    assign pick_data = data_m_access;
`endif

    // In IDLE the access fields come straight from the winning port so a
    // zero-wait-state grant can perform its access on the edge into ACK.
    always_comb begin
        acc_data  = gnt_data;
        acc_addr  = lat_addr;
        acc_wr    = lat_wr;
        acc_bsel  = lat_bsel;
        acc_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            acc_data  = pick_data;
            acc_addr  = pick_data ? data_m_addr[ADDR_WIDTH:1] : instr_m_addr[ADDR_WIDTH:1];
            acc_wr    = pick_data & data_m_wr_en;
            acc_bsel  = data_m_bytesel;
            acc_wdata = data_m_data_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
            ST_WAIT: if (wait_cnt <= 4'd1) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_ack = (state_nxt == ST_ACK) && (state != ST_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            gnt_data  <= 1'b0;
            lat_addr  <= '0;
            lat_wr    <= 1'b0;
            lat_bsel  <= 2'b00;
            lat_wdata <= 16'h0000;
            instr_rd  <= 16'h0000;
            data_rd   <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                gnt_data  <= pick_data;
                lat_addr  <= acc_addr;
                lat_wr    <= acc_wr;
                lat_bsel  <= acc_bsel;
                lat_wdata <= acc_wdata;
                wait_cnt  <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_ack && !acc_wr) begin
                if (acc_data) data_rd  <= mem[acc_addr];
                else          instr_rd <= mem[acc_addr];
            end
        end
    end

    // Store is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && enter_ack && acc_data && acc_wr) begin
            if (acc_bsel[0]) mem[acc_addr][7:0]  <= acc_wdata[7:0];
            if (acc_bsel[1]) mem[acc_addr][15:8] <= acc_wdata[15:8];
        end
    end

    assign instr_m_ack      = (state == ST_ACK) && !gnt_data;
    assign data_m_ack       = (state == ST_ACK) && gnt_data;
    assign instr_m_data_out = instr_rd;
    assign data_m_data_out  = data_rd;

endmodule

// File: tb/tb_dual_bus_responder.sv
// Scoreboard bench for dual_bus_responder: WAIT_STATES=1 main instance plus a WAIT_STATES=0 instance.
module tb_dual_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:1] instr_m_addr = '0;
    logic        instr_m_access = 1'b0;
    logic        instr_m_ack;
    logic [15:0] instr_m_data_out;
    logic [19:1] data_m_addr = '0;
    logic        data_m_access = 1'b0;
    logic        data_m_wr_en = 1'b0;
    logic [1:0]  data_m_bytesel = 2'b00;
    logic [15:0] data_m_data_in = '0;
    logic [15:0] data_m_data_out;
    logic        data_m_ack;

    logic [19:1] z_instr_addr = '0;
    logic        z_instr_access = 1'b0;
    logic        z_instr_ack;
    logic [15:0] z_instr_dout;
    logic [19:1] z_data_addr = '0;
    logic        z_data_access = 1'b0;
    logic        z_data_wr = 1'b0;
    logic [1:0]  z_data_bsel = 2'b11;
    logic [15:0] z_data_wdata = '0;
    logic [15:0] z_data_dout;
    logic        z_data_ack;

    logic [16:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] last_d = 16'h0000;

    always #5 clk = ~clk;

    dual_bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset),
        .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
        .instr_m_ack(instr_m_ack), .instr_m_data_out(instr_m_data_out),
        .data_m_addr(data_m_addr), .data_m_access(data_m_access),
        .data_m_wr_en(data_m_wr_en), .data_m_bytesel(data_m_bytesel),
        .data_m_data_in(data_m_data_in), .data_m_data_out(data_m_data_out),
        .data_m_ack(data_m_ack)
    );

    dual_bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .instr_m_addr(z_instr_addr), .instr_m_access(z_instr_access),
        .instr_m_ack(z_instr_ack), .instr_m_data_out(z_instr_dout),
        .data_m_addr(z_data_addr), .data_m_access(z_data_access),
        .data_m_wr_en(z_data_wr), .data_m_bytesel(z_data_bsel),
        .data_m_data_in(z_data_wdata), .data_m_data_out(z_data_dout),
        .data_m_ack(z_data_ack)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected {is_data, data_out} entry.
    always @(negedge clk) begin
        if (!reset && (instr_m_ack || data_m_ack)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: got instr=%b data=%b expected none", instr_m_ack, data_m_ack);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("ack_port", {14'b0, instr_m_ack, data_m_ack}, e[16] ? 16'h0001 : 16'h0002);
                check(e[16] ? "data_out" : "instr_out", e[16] ? data_m_data_out : instr_m_data_out, e[15:0]);
            end
        end
    end

    task automatic data_op(input logic wr, input logic [18:0] a, input logic [1:0] bs,
                           input logic [15:0] wd, input logic [15:0] exp_out);
        int lat;
        logic got;
        @(negedge clk);
        data_m_addr = a; data_m_wr_en = wr; data_m_bytesel = bs; data_m_data_in = wd;
        data_m_access = 1'b1;
        exp_q.push_back({1'b1, exp_out});
        lat = 0; got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (data_m_ack) got = 1'b1;
        end
        data_m_access = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL data_ack_timeout: got no ack expected ack within 50 cycles");
        end else check("data_latency", 16'(lat), 16'd2);
    endtask

    task automatic instr_op(input logic [18:0] a, input logic [15:0] exp_out);
        int lat;
        logic got;
        @(negedge clk);
        instr_m_addr = a;
        instr_m_access = 1'b1;
        exp_q.push_back({1'b0, exp_out});
        lat = 0; got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (instr_m_ack) got = 1'b1;
        end
        instr_m_access = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL instr_ack_timeout: got no ack expected ack within 50 cycles");
        end else check("instr_latency", 16'(lat), 16'd2);
    endtask

    task automatic z_op(input logic is_instr, input logic [18:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd);
        @(negedge clk);
        if (is_instr) begin
            z_instr_addr = a; z_instr_access = 1'b1;
        end else begin
            z_data_addr = a; z_data_wr = 1'b1; z_data_wdata = wd; z_data_access = 1'b1;
        end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (is_instr ? z_instr_ack : z_data_ack) break;
        end
        z_instr_access = 1'b0;
        z_data_access = 1'b0;
        rd = is_instr ? z_instr_dout : z_data_dout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int acks;
        int cyc;
        logic [15:0] rd;

        repeat (3) @(negedge clk);
        check("rst_instr_ack", {15'b0, instr_m_ack}, 16'h0000);
        check("rst_data_ack", {15'b0, data_m_ack}, 16'h0000);
        check("rst_instr_out", instr_m_data_out, 16'h0000);
        check("rst_data_out", data_m_data_out, 16'h0000);
        reset = 1'b0;

        // Zero wait states: ack in the cycle after the grant.
        z_op(1'b0, 19'h00003, 16'h1357, lat, rd);
        check("z_write_latency", 16'(lat), 16'd1);
        z_op(1'b1, 19'h00003, 16'h0000, lat, rd);
        check("z_read_latency", 16'(lat), 16'd1);
        check("z_read_data", rd, 16'h1357);

        // Full write, then partial and empty byte-select writes.
        data_op(1'b1, 19'h00010, 2'b11, 16'hBEEF, last_d);
        last_d = 16'hBEEF;
        data_op(1'b0, 19'h00010, 2'b11, 16'h0000, last_d);
        data_op(1'b1, 19'h00010, 2'b01, 16'h1234, last_d);
        last_d = 16'hBE34;
        data_op(1'b0, 19'h00010, 2'b11, 16'h0000, last_d);
        data_op(1'b1, 19'h00010, 2'b00, 16'hFFFF, last_d);
        data_op(1'b0, 19'h00010, 2'b11, 16'h0000, last_d);

        // Aliasing through the ignored upper address bits.
        data_op(1'b1, 19'h00005, 2'b11, 16'hA5A5, last_d);
        instr_op(19'h00405, 16'hA5A5);
        data_op(1'b1, 19'h00405, 2'b10, 16'h7700, last_d);
        last_d = 16'h77A5;
        data_op(1'b0, 19'h00005, 2'b11, 16'h0000, last_d);

        // Both ports requesting continuously.
        @(negedge clk);
        data_m_addr = 19'h00010; data_m_wr_en = 1'b0; data_m_access = 1'b1;
        instr_m_addr = 19'h00005; instr_m_access = 1'b1;
`ifdef DUAL_BUS_RESPONDER_RR_EN
        exp_q.push_back({1'b0, 16'h77A5});
        exp_q.push_back({1'b1, 16'hBE34});
        exp_q.push_back({1'b0, 16'h77A5});
        exp_q.push_back({1'b1, 16'hBE34});
`else
        repeat (4) exp_q.push_back({1'b1, 16'hBE34});
`endif
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (instr_m_ack || data_m_ack) acks++;
        end
        data_m_access = 1'b0;
        instr_m_access = 1'b0;
        check("contention_acks", 16'(acks), 16'd4);
        last_d = 16'hBE34;
        repeat (4) @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
`ifndef DUAL_BUS_RESPONDER_RR_EN
        check("instr_out_held", instr_m_data_out, 16'hA5A5);
`endif

        // Reset during the wait state of a write aborts it.
        data_op(1'b1, 19'h00020, 2'b11, 16'h0000, last_d);
        @(negedge clk);
        data_m_addr = 19'h00020; data_m_wr_en = 1'b1; data_m_bytesel = 2'b11;
        data_m_data_in = 16'hFFFF; data_m_access = 1'b1;
        @(negedge clk);
        check("wait_no_ack", {15'b0, data_m_ack}, 16'h0000);
        reset = 1'b1;
        data_m_access = 1'b0;
        @(negedge clk);
        check("abort_data_ack", {14'b0, instr_m_ack, data_m_ack}, 16'h0000);
        check("abort_data_out", data_m_data_out, 16'h0000);
        check("abort_instr_out", instr_m_data_out, 16'h0000);
        reset = 1'b0;
        last_d = 16'h0000;
        repeat (4) @(negedge clk);
        data_op(1'b0, 19'h00020, 2'b11, 16'h0000, 16'h0000);
        instr_op(19'h00020, 16'h0000);

        repeat (4) @(negedge clk);
        check("final_queue_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
